// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the miniRV pipeline controller.
//   pipe_state_e  - controller FSM states (encodings visible on state_o)
//   HOLD_ENABLE / FLUSH_ENABLE - asserted levels of the hold/flush controls
//   load_use_hit  - load-use hazard detect between the load in EX and id reads
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PIPE_RUN      = 2'd0,
      PIPE_LU_STALL = 2'd1,
      PIPE_DIV_WAIT = 2'd2
   } pipe_state_e;

   localparam logic HOLD_ENABLE  = 1'b1;
   localparam logic FLUSH_ENABLE = 1'b1;

   // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
   function automatic logic load_use_hit(input logic       mem_re,
                                         input logic [4:0] waddr,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return mem_re && (waddr != 5'd0) && ((waddr == rs1) || (waddr == rs2));
   endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 3-stage miniRV pipeline.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   id_reg1/2_raddr_i   - rs1/rs2 read addresses in id (0 = unused)
//   ex_mem_re_i         - instruction in EX is a load
//   ex_reg_waddr_i      - destination register of instruction in EX
//   ex_jump_flag_i      - EX resolved a taken branch/jump
//   ex_jump_addr_i      - redirect target (pc+4 when a divide starts)
//   div_start_i         - EX issued a divide/remainder this cycle
//   div_ready_i         - divider result written back this cycle
//   hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o - pipeline controls
//   jump_flag_o, jump_addr_o - PC redirect (address 0 when no redirect)
//   div_timeout_o       - sticky divide watchdog flag
//   stall_cnt_o         - count of cycles with hold_pc_o set (wraps)
//   state_o             - current FSM state for debug
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_reg1_raddr_i,
   input  logic [4:0]       id_reg2_raddr_i,
   input  logic             ex_mem_re_i,
   input  logic [4:0]       ex_reg_waddr_i,
   input  logic             ex_jump_flag_i,
   input  logic [31:0]      ex_jump_addr_i,
   input  logic             div_start_i,
   input  logic             div_ready_i,
   output logic             hold_pc_o,
   output logic             hold_if_id_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             jump_flag_o,
   output logic [31:0]      jump_addr_o,
   output logic             div_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [1:0]       state_o
);

   localparam int unsigned     WAIT_W    = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV_TIMEOUT - 1);

   pipe_state_e       state_q, state_d;
   logic [31:0]       ret_addr_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              timeout_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic        hold_pc_c, hold_if_id_c, flush_if_id_c, flush_id_ex_c, jump_c;
   logic [31:0] jump_addr_c;
   logic        capture_ret;
   logic        timeout_release;

   always_comb begin
      hold_pc_c       = 1'b0;
      hold_if_id_c    = 1'b0;
      flush_if_id_c   = 1'b0;
      flush_id_ex_c   = 1'b0;
      jump_c          = 1'b0;
      jump_addr_c     = '0;
      capture_ret     = 1'b0;
      timeout_release = 1'b0;
      state_d         = state_q;

      case (state_q)
         // LU_STALL shares the RUN path: EX holds a bubble there, so the divide
         // and hazard branches are gated to RUN and only the jump applies.
         PIPE_RUN, PIPE_LU_STALL: begin
            state_d = PIPE_RUN;
            if ((state_q == PIPE_RUN) && div_start_i) begin
               hold_pc_c     = HOLD_ENABLE;
               flush_if_id_c = FLUSH_ENABLE;
               flush_id_ex_c = FLUSH_ENABLE;
               capture_ret   = 1'b1;
               state_d       = PIPE_DIV_WAIT;
            end else if (ex_jump_flag_i) begin
               jump_c        = 1'b1;
               jump_addr_c   = ex_jump_addr_i;
               flush_if_id_c = FLUSH_ENABLE;
               flush_id_ex_c = FLUSH_ENABLE;
            end else if ((state_q == PIPE_RUN) &&
                         load_use_hit(ex_mem_re_i, ex_reg_waddr_i,
                                      id_reg1_raddr_i, id_reg2_raddr_i)) begin
               hold_pc_c     = HOLD_ENABLE;
               hold_if_id_c  = HOLD_ENABLE;
               flush_id_ex_c = FLUSH_ENABLE;
               state_d       = PIPE_LU_STALL;
            end
         end
         PIPE_DIV_WAIT: begin
            flush_if_id_c = FLUSH_ENABLE;
            flush_id_ex_c = FLUSH_ENABLE;
            if (div_ready_i || (wait_cnt_q == WAIT_LAST)) begin
               jump_c          = 1'b1;
               jump_addr_c     = ret_addr_q;
               timeout_release = ~div_ready_i;
               state_d         = PIPE_RUN;
            end else begin
               hold_pc_c = HOLD_ENABLE;
            end
         end
         default: state_d = PIPE_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PIPE_RUN;
         ret_addr_q  <= '0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture_ret) begin
            ret_addr_q <= ex_jump_addr_i;
            wait_cnt_q <= '0;
         end else if (state_q == PIPE_DIV_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
         if (timeout_release) timeout_q <= 1'b1;
         if (hold_pc_c) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   // Every output, registered ones included, reads as zero while reset is held.
   assign hold_pc_o     = hold_pc_c & ~rst;
   assign hold_if_id_o  = hold_if_id_c & ~rst;
   assign flush_if_id_o = flush_if_id_c & ~rst;
   assign flush_id_ex_o = flush_id_ex_c & ~rst;
   assign jump_flag_o   = jump_c & ~rst;
   assign jump_addr_o   = (jump_c && !rst) ? jump_addr_c : '0;
   assign div_timeout_o = timeout_q & ~rst;
   assign stall_cnt_o   = rst ? '0 : stall_cnt_q;
   assign state_o       = rst ? 2'd0 : state_q;

   a_no_div_with_jump : assert property (@(posedge clk) disable iff (rst)
      (state_q == PIPE_RUN) |-> !(div_start_i && ex_jump_flag_i));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Two instances share stimulus:
// u_dut (DIV_TIMEOUT=64) and u_wd (DIV_TIMEOUT=8), both checked every cycle
// against a behavioural model, plus table vectors and directed sequences.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  rs1, rs2, waddr;
   logic        mem_re, jf, dstart, dready;
   logic [31:0] jaddr;

   logic        hp0, hi0, fi0, fe0, jo0, to0;
   logic [31:0] ja0, cnt0;
   logic [1:0]  st0;
   logic        hp1, hi1, fi1, fe1, jo1, to1;
   logic [31:0] ja1, cnt1;
   logic [1:0]  st1;

   logic [71:0] ov [2];

   int n_vec = 0;
   int n_err = 0;

   pipe_ctrl #(.DIV_TIMEOUT(64), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2),
      .ex_mem_re_i(mem_re), .ex_reg_waddr_i(waddr),
      .ex_jump_flag_i(jf), .ex_jump_addr_i(jaddr),
      .div_start_i(dstart), .div_ready_i(dready),
      .hold_pc_o(hp0), .hold_if_id_o(hi0), .flush_if_id_o(fi0), .flush_id_ex_o(fe0),
      .jump_flag_o(jo0), .jump_addr_o(ja0), .div_timeout_o(to0),
      .stall_cnt_o(cnt0), .state_o(st0));

   pipe_ctrl #(.DIV_TIMEOUT(8), .CNT_W(32)) u_wd (
      .clk(clk), .rst(rst),
      .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2),
      .ex_mem_re_i(mem_re), .ex_reg_waddr_i(waddr),
      .ex_jump_flag_i(jf), .ex_jump_addr_i(jaddr),
      .div_start_i(dstart), .div_ready_i(dready),
      .hold_pc_o(hp1), .hold_if_id_o(hi1), .flush_if_id_o(fi1), .flush_id_ex_o(fe1),
      .jump_flag_o(jo1), .jump_addr_o(ja1), .div_timeout_o(to1),
      .stall_cnt_o(cnt1), .state_o(st1));

   assign ov[0] = {hp0, hi0, fi0, fe0, jo0, ja0, to0, cnt0, st0};
   assign ov[1] = {hp1, hi1, fi1, fe1, jo1, ja1, to1, cnt1, st1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 running, 1 one cycle after a load-use stall, 2 waiting on divider
   int          m_mode [2];
   logic [31:0] m_ret  [2];
   int          m_wait [2];
   logic        m_to   [2];
   logic [31:0] m_cnt  [2];
   int          m_tmo  [2];
   logic [71:0] ev     [2];
   int          e_next [2];
   bit          e_trel [2];
   bit          e_cap  [2];

   task automatic model_eval(input int k);
      logic hp, hi, fi, fe, jo;
      logic [31:0] ja;
      hp = 0; hi = 0; fi = 0; fe = 0; jo = 0; ja = '0;
      e_next[k] = 0; e_trel[k] = 0; e_cap[k] = 0;
      if (m_mode[k] == 2) begin
         fi = 1; fe = 1;
         if (dready || (m_wait[k] == m_tmo[k] - 1)) begin
            jo = 1; ja = m_ret[k]; e_trel[k] = !dready;
         end else begin
            hp = 1; e_next[k] = 2;
         end
      end else if (m_mode[k] == 0 && dstart) begin
         hp = 1; fi = 1; fe = 1; e_next[k] = 2; e_cap[k] = 1;
      end else if (jf) begin
         jo = 1; ja = jaddr; fi = 1; fe = 1;
      end else if (m_mode[k] == 0 && mem_re && waddr != 0 && (waddr == rs1 || waddr == rs2)) begin
         hp = 1; hi = 1; fe = 1; e_next[k] = 1;
      end
      if (rst) ev[k] = '0;
      else ev[k] = {hp, hi, fi, fe, jo, ja, m_to[k], m_cnt[k], 2'(m_mode[k])};
   endtask

   task automatic model_update(input int k);
      if (rst) begin
         m_mode[k] = 0; m_ret[k] = '0; m_wait[k] = 0; m_to[k] = 0; m_cnt[k] = '0;
      end else begin
         if (ev[k][71]) m_cnt[k] = m_cnt[k] + 32'd1;
         if (e_cap[k]) begin
            m_ret[k] = jaddr; m_wait[k] = 0;
         end else if (m_mode[k] == 2) begin
            m_wait[k] = m_wait[k] + 1;
         end
         if (e_trel[k]) m_to[k] = 1;
         m_mode[k] = e_next[k];
      end
   endtask

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: model predicts, outputs compared at negedge, model advances at posedge.
   task automatic cyc();
      for (int k = 0; k < 2; k++) model_eval(k);
      @(negedge clk);
      chk("model_dut", ov[0], ev[0]);
      chk("model_wd", ov[1], ev[1]);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_update(k);
      #1;
   endtask

   task automatic idle();
      rs1 = '0; rs2 = '0; waddr = '0; mem_re = 0; jf = 0; jaddr = '0;
      dstart = 0; dready = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      #1;
      chk("rst_outs_dut", ov[0], '0);
      chk("rst_outs_wd", ov[1], '0);
      cyc();
      rst = 0;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic [4:0]  rs1, rs2;
      logic        mem_re;
      logic [4:0]  waddr;
      logic        jf;
      logic [31:0] jaddr;
      logic [4:0]  ctl;   // {hold_pc, hold_if_id, flush_if_id, flush_id_ex, jump_flag}
      logic [31:0] ja;
      logic [1:0]  nxt;
   } tv_t;

   tv_t tv [9];
   int  holds;

   initial begin
      tv[0] = '{5'd5,  5'd0,  1'b1, 5'd5,  1'b0, 32'h0,        5'b11010, 32'h0,        2'd1};
      tv[1] = '{5'd3,  5'd7,  1'b1, 5'd7,  1'b0, 32'h0,        5'b11010, 32'h0,        2'd1};
      tv[2] = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'h0,        5'b00000, 32'h0,        2'd0};
      tv[3] = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b0, 32'h0,        5'b00000, 32'h0,        2'd0};
      tv[4] = '{5'd1,  5'd2,  1'b1, 5'd9,  1'b0, 32'h0,        5'b00000, 32'h0,        2'd0};
      tv[5] = '{5'd5,  5'd0,  1'b1, 5'd5,  1'b1, 32'h100,      5'b00111, 32'h100,      2'd0};
      tv[6] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 32'hDEADBEE0, 5'b00111, 32'hDEADBEE0, 2'd0};
      tv[7] = '{5'd4,  5'd6,  1'b0, 5'd2,  1'b0, 32'h1234,     5'b00000, 32'h0,        2'd0};
      tv[8] = '{5'd0,  5'd31, 1'b1, 5'd31, 1'b0, 32'h0,        5'b11010, 32'h0,        2'd1};

      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_ret[k] = '0; m_wait[k] = 0; m_to[k] = 0; m_cnt[k] = '0;
      end
      m_tmo[0] = 64;
      m_tmo[1] = 8;

      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      chk("post_rst_state", st0, 2'd0);
      chk("post_rst_cnt", cnt0, 32'd0);

      for (int i = 0; i < 9; i++) begin
         rs1 = tv[i].rs1; rs2 = tv[i].rs2; mem_re = tv[i].mem_re;
         waddr = tv[i].waddr; jf = tv[i].jf; jaddr = tv[i].jaddr;
         #1;
         chk($sformatf("tbl%0d_ctl", i), {hp0, hi0, fi0, fe0, jo0}, tv[i].ctl);
         chk($sformatf("tbl%0d_addr", i), ja0, tv[i].ja);
         cyc();
         idle();
         chk($sformatf("tbl%0d_next", i), st0, tv[i].nxt);
         cyc();
      end

      // Load-use: one stall cycle, a quiet LU_STALL cycle, then back to RUN.
      do_reset();
      mem_re = 1; waddr = 5'd5; rs1 = 5'd5;
      #1;
      chk("lu_ctl", {hp0, hi0, fi0, fe0, jo0}, 5'b11010);
      cyc();
      chk("lu_state", st0, 2'd1);
      #1;
      chk("lu_stall_ctl", {hp0, hi0, fi0, fe0, jo0}, 5'b00000);
      idle();
      cyc();
      chk("lu_back_run", st0, 2'd0);
      chk("lu_cnt", cnt0, 32'd1);

      // Divide: start with return 0x84, ready 33 cycles later.
      do_reset();
      holds = 0;
      dstart = 1; jaddr = 32'h84;
      #1;
      if (hp0) holds++;
      cyc();
      idle();
      for (int i = 1; i < 33; i++) begin
         #1;
         if (hp0) holds++;
         cyc();
      end
      dready = 1;
      #1;
      chk("div_ready_jump", {hp0, jo0, ja0}, {1'b0, 1'b1, 32'h84});
      cyc();
      idle();
      chk("div_holds", 32'(holds), 32'd33);
      chk("div_cnt", cnt0, 32'd33);
      chk("div_timeout_clear", to0, 1'b0);
      chk("div_state_run", st0, 2'd0);

      // Watchdog on the DIV_TIMEOUT=8 instance.
      do_reset();
      dstart = 1; jaddr = 32'h200;
      cyc();
      idle();
      for (int i = 1; i <= 8; i++) begin
         #1;
         if (i < 8) chk($sformatf("wd_wait%0d", i), {hp1, jo1}, 2'b10);
         else chk("wd_forced_jump", {hp1, jo1, ja1}, {1'b0, 1'b1, 32'h200});
         cyc();
      end
      chk("wd_timeout_set", to1, 1'b1);
      chk("wd_state_run", st1, 2'd0);
      repeat (100) cyc();
      chk("wd_timeout_sticky", to1, 1'b1);

      // Reset in the middle of a divide wait (wait count 5).
      do_reset();
      dstart = 1; jaddr = 32'h300;
      cyc();
      idle();
      repeat (5) cyc();
      rst = 1;
      #1;
      chk("midrst_outs", ov[0], '0);
      cyc();
      rst = 0;
      #1;
      chk("midrst_after", {st0, cnt0, to0, jo0}, '0);
      cyc();
      chk("midrst_state", st0, 2'd0);

      // Randomised traffic, checked by the model on both instances.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         rs1    = 5'($urandom_range(0, 3));
         rs2    = 5'($urandom_range(0, 3));
         waddr  = 5'($urandom_range(0, 3));
         mem_re = 1'($urandom_range(0, 1));
         jaddr  = $urandom;
         dstart = ($urandom_range(0, 15) == 0);
         jf     = !dstart && ($urandom_range(0, 7) == 0);
         dready = ($urandom_range(0, 39) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
